hpm_sample_ctrl: RTL and testbench
==================================

Name: hpm_sample_ctrl

Overview:
Autonomous sampling scheduler for the hardware performance monitor (HPM) MMIO register port. It owns that port and shares it between the CPU MMIO master, which has strict priority, and an internal sampler. Every cfg_interval cycles the sampler reads the four HPM counters (cycle, inst, mem-rd, mem-wr). It pushes each 4-word record into a word FIFO that a trace or DMA consumer drains over a valid/ready stream.

Parameters:
DEPTH, 16, FIFO depth in 32-bit words; power of 2, minimum 4.
DROP_W, 16, width of the saturating dropped-record counter.

Ports:
clk  in  1  clock
rst_n  in  1  reset, asynchronous, active-low
cfg_enable  in  1  sampler enable (level)
cfg_interval  in  32  sample period in cycles; values below 4 are treated as 4
cpu_cs  in  1  CPU MMIO select to HPM
cpu_we  in  1  CPU write enable
cpu_addr  in  5  CPU register address
cpu_wdata  in  32  CPU write data
cpu_rdata  out  32  CPU read data
hpm_cs  out  1  HPM select
hpm_we  out  1  HPM write enable
hpm_addr  out  5  HPM address
hpm_wdata  out  32  HPM write data
hpm_rdata  in  32  HPM read data (combinational, same cycle)
smp_valid  out  1  FIFO head valid
smp_data  out  32  FIFO head word
smp_last  out  1  head word is the 4th (mem-wr) word of a record
smp_ready  in  1  consumer accepts head
drop_cnt  out  DROP_W  records dropped because the FIFO lacked room (saturating)
busy  out  1  FSM in READ state

Behaviour:
- Reset: FSM = IDLE, timer = 0, FIFO empty. smp_valid = 0, smp_last = 0, smp_data = 0, drop_cnt = 0, busy = 0, hpm_cs = 0.
- Port mux (combinational):
  - cpu_cs = 1: hpm_* = cpu_* pass-through; cpu_rdata = hpm_rdata.
  - cpu_cs = 0: hpm_cs = smp_grant, hpm_we = 0, hpm_addr = sampler address, hpm_wdata = 0.
  - cpu_rdata = 0 whenever cpu_cs = 0.
  - smp_grant = (state == READ) && !cpu_cs. The CPU never stalls.
- FSM states: IDLE, COUNT, READ. Word index idx is 2 bits.
- IDLE:
  - cfg_enable = 1: load timer = max(cfg_interval, 4) - 1, go to COUNT.
- COUNT:
  - Timer decrements once per cycle.
  - cfg_enable = 0: go to IDLE next cycle.
  - Timer == 0 and free words >= 4: go to READ with idx = 0.
  - Timer == 0 and free words < 4: increment drop_cnt (saturating at all-ones), reload timer, stay in COUNT.
- READ:
  - In each cycle with smp_grant = 1: hpm_addr = 5'h04 + 4*idx. Push {last = (idx == 3), hpm_rdata} into the FIFO, then idx++.
  - Cycles with cpu_cs = 1 push nothing and hold idx.
  - After the idx = 3 push: if cfg_enable = 1, reload timer and go to COUNT; otherwise go to IDLE.
  - Deasserting cfg_enable mid-READ never truncates a record; partial records never exist in the FIFO.
- Latency: with no CPU contention, a record occupies exactly 4 consecutive READ cycles. The first word is visible on smp_valid the cycle after its push. Period = cfg_interval cycles from one READ entry to the next, plus any CPU stall cycles.
- Timer freezes during READ. cfg_interval is sampled only at each load.
- FIFO:
  - DEPTH x 33 bits, first-word-fall-through; smp_valid = !empty.
  - Pop when smp_valid && smp_ready.
  - Simultaneous push and pop is legal; occupancy is unchanged.
  - Free-space check is made in COUNT at timer == 0. Pops can only add room, so the record cannot overflow mid-READ.
- The sampler never writes HPM registers. CPU writes (e.g. counter clear) may land between record words; this is accepted and records are not atomic.
- Asynchronous reset mid-READ discards the FIFO contents and returns the FSM to IDLE.

Test Plan:
- Interval 10, enable, no CPU traffic, smp_ready = 1 -> READ entered every 10 cycles. hpm_addr sequence is 04, 08, 0C, 10; four FIFO words with smp_last = 1 only on the 4th; drop_cnt = 0.
- cfg_interval = 1 -> behaves exactly as interval 4 (READ entries 4 cycles apart).
- cpu_cs held high during READ idx 1 for 3 cycles, reading address 0x00 -> CPU sees hpm_rdata; the sampler pushes nothing for 3 cycles, then resumes at addr 0x08; the record completes intact.
- DEPTH = 16, smp_ready = 0, interval 8 -> 4 records stored (16 words). Subsequent expiries increment drop_cnt 1, 2, 3, and no push occurs.
- cfg_enable dropped on the cycle of READ idx 1 -> idx 2 and 3 still pushed, FSM reaches IDLE, no further reads occur.
- rst_n asserted mid-READ -> smp_valid = 0, drop_cnt = 0, hpm_cs = 0 immediately; after release with enable held, the first READ begins max(cfg_interval, 4) cycles later.

Source files
------------

// File: rtl/hpm_sample_ctrl.sv
// Generic word FIFO, first-word-fall-through: a write is visible on rd_dat the next cycle.
// Reads are ignored while empty and writes are dropped while full; the owner tracks room via cnt.
module sync_fifo #(
    parameter  int WIDTH = 33,
    parameter  int DEPTH = 16,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             wr_vld,
    input  logic [WIDTH-1:0] wr_dat,
    input  logic             rd_rdy,
    output logic             rd_vld,
    output logic [WIDTH-1:0] rd_dat,
    output logic [AW:0]      cnt
);
    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             full;
    logic             do_wr;
    logic             do_rd;

    assign full   = (cnt == (AW+1)'(DEPTH));
    assign rd_vld = (cnt != '0);
    assign rd_dat = mem[rd_ptr];
    assign do_rd  = rd_rdy && rd_vld;
    assign do_wr  = wr_vld && (!full || do_rd);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (do_wr) wr_ptr <= wr_ptr + AW'(1);
            if (do_rd) rd_ptr <= rd_ptr + AW'(1);
            cnt <= cnt + (AW+1)'(do_wr) - (AW+1)'(do_rd);
        end
    end

    always_ff @(posedge clk) begin
        if (do_wr) mem[wr_ptr] <= wr_dat;
    end
endmodule

// HPM sampling scheduler: CPU-priority mux on the HPM port, periodic 4-word counter records into a FIFO.
// Latency: record words pushed on 4 granted READ cycles, visible next cycle; backpressure: full FIFO drops whole records.
module hpm_sample_ctrl #(
    parameter int DEPTH  = 16,
    parameter int DROP_W = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cfg_enable,
    input  logic [31:0]       cfg_interval,
    input  logic              cpu_cs,
    input  logic              cpu_we,
    input  logic [4:0]        cpu_addr,
    input  logic [31:0]       cpu_wdata,
    output logic [31:0]       cpu_rdata,
    output logic              hpm_cs,
    output logic              hpm_we,
    output logic [4:0]        hpm_addr,
    output logic [31:0]       hpm_wdata,
    input  logic [31:0]       hpm_rdata,
    output logic              smp_valid,
    output logic [31:0]       smp_data,
    output logic              smp_last,
    input  logic              smp_ready,
    output logic [DROP_W-1:0] drop_cnt,
    output logic              busy
);
    localparam int AW = $clog2(DEPTH);

    typedef enum logic [1:0] {IDLE, COUNT, READ} state_t;

    state_t            state_q, state_d;
    logic [31:0]       timer_q, timer_d;
    logic [1:0]        idx_q, idx_d;
    logic [DROP_W-1:0] drop_q, drop_d;
    logic [DROP_W-1:0] drop_sat;
    logic [31:0]       n_eff;
    logic              smp_grant;
    logic              pop;
    logic [4:0]        smp_addr;
    logic [32:0]       push_dat;
    logic [32:0]       head_dat;
    logic              head_vld;
    logic [AW:0]       fifo_cnt;
    logic [AW+1:0]     cnt_after;
    logic              room_now;
    logic              room_after;

    assign n_eff     = (cfg_interval < 32'd4) ? 32'd4 : cfg_interval;
    assign smp_grant = (state_q == READ) && !cpu_cs;
    assign smp_addr  = 5'h04 + {1'b0, idx_q, 2'b00};
    assign push_dat  = {(idx_q == 2'd3), hpm_rdata};
    assign pop       = head_vld && smp_ready;
    assign drop_sat  = (drop_q == '1) ? drop_q : drop_q + DROP_W'(1);

    // Room for a fresh record, now or once the current (final) word lands.
    assign room_now   = (fifo_cnt <= (AW+1)'(DEPTH - 4));
    assign cnt_after  = {1'b0, fifo_cnt} + (AW+2)'(1) - (AW+2)'(pop);
    assign room_after = (cnt_after <= (AW+2)'(DEPTH - 4));

    assign hpm_cs    = cpu_cs | smp_grant;
    assign hpm_we    = cpu_cs & cpu_we;
    assign hpm_addr  = cpu_cs ? cpu_addr : smp_addr;
    assign hpm_wdata = cpu_cs ? cpu_wdata : 32'd0;
    assign cpu_rdata = cpu_cs ? hpm_rdata : 32'd0;

    assign smp_valid = head_vld;
    assign smp_data  = head_vld ? head_dat[31:0] : 32'd0;
    assign smp_last  = head_vld & head_dat[32];
    assign drop_cnt  = drop_q;
    assign busy      = (state_q == READ);

    always_comb begin
        state_d = state_q;
        timer_d = timer_q;
        idx_d   = idx_q;
        drop_d  = drop_q;
        case (state_q)
            IDLE: begin
                if (cfg_enable) begin
                    timer_d = n_eff - 32'd1;
                    state_d = COUNT;
                end
            end
            COUNT: begin
                if (!cfg_enable) begin
                    state_d = IDLE;
                end else if (timer_q == '0) begin
                    if (room_now) begin
                        idx_d   = 2'd0;
                        state_d = READ;
                    end else begin
                        drop_d  = drop_sat;
                        timer_d = n_eff - 32'd1;
                    end
                end else begin
                    timer_d = timer_q - 32'd1;
                end
            end
            READ: begin
                if (smp_grant) begin
                    idx_d = idx_q + 2'd1;
                    if (idx_q == 2'd3) begin
                        // Four READ cycles already spent count toward the period; at the
                        // minimum period the next expiry coincides with the last push.
                        if (!cfg_enable) begin
                            state_d = IDLE;
                        end else if (n_eff == 32'd4) begin
                            if (room_after) begin
                                state_d = READ;
                            end else begin
                                drop_d  = drop_sat;
                                timer_d = n_eff - 32'd1;
                                state_d = COUNT;
                            end
                        end else begin
                            timer_d = n_eff - 32'd5;
                            state_d = COUNT;
                        end
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            timer_q <= '0;
            idx_q   <= '0;
            drop_q  <= '0;
        end else begin
            state_q <= state_d;
            timer_q <= timer_d;
            idx_q   <= idx_d;
            drop_q  <= drop_d;
        end
    end

    sync_fifo #(
        .WIDTH (33),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk    (clk),
        .rst_n  (rst_n),
        .wr_vld (smp_grant),
        .wr_dat (push_dat),
        .rd_rdy (smp_ready),
        .rd_vld (head_vld),
        .rd_dat (head_dat),
        .cnt    (fifo_cnt)
    );
endmodule

// File: tb/tb_hpm_sample_ctrl.sv
// Directed bench for hpm_sample_ctrl: port-mux vector table plus hand-written sampling sequences.
module tb_hpm_sample_ctrl;
    localparam int DEPTH  = 16;
    localparam int DROP_W = 16;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              cfg_enable = 1'b0;
    logic [31:0]       cfg_interval = 32'd10;
    logic              cpu_cs = 1'b0;
    logic              cpu_we = 1'b0;
    logic [4:0]        cpu_addr = 5'h00;
    logic [31:0]       cpu_wdata = 32'h0;
    logic [31:0]       cpu_rdata;
    logic              hpm_cs;
    logic              hpm_we;
    logic [4:0]        hpm_addr;
    logic [31:0]       hpm_wdata;
    logic [31:0]       hpm_rdata;
    logic              smp_valid;
    logic [31:0]       smp_data;
    logic              smp_last;
    logic              smp_ready = 1'b1;
    logic [DROP_W-1:0] drop_cnt;
    logic              busy;
    logic [15:0]       tag = 16'h1234;

    always #5 clk = ~clk;

    // HPM slave model: register value encodes its own address.
    assign hpm_rdata = {11'h5A5, hpm_addr, tag};

    hpm_sample_ctrl #(.DEPTH(DEPTH), .DROP_W(DROP_W)) dut (
        .clk(clk), .rst_n(rst_n), .cfg_enable(cfg_enable), .cfg_interval(cfg_interval),
        .cpu_cs(cpu_cs), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_rdata(cpu_rdata), .hpm_cs(hpm_cs), .hpm_we(hpm_we), .hpm_addr(hpm_addr),
        .hpm_wdata(hpm_wdata), .hpm_rdata(hpm_rdata), .smp_valid(smp_valid),
        .smp_data(smp_data), .smp_last(smp_last), .smp_ready(smp_ready),
        .drop_cnt(drop_cnt), .busy(busy)
    );

    int          tests = 0;
    int          fails = 0;
    int          cyc = 0;
    int          g_cyc[$];
    logic [4:0]  g_addr[$];
    int          p_cyc[$];
    logic [32:0] p_word[$];

    always @(negedge clk) begin
        cyc = cyc + 1;
        if (rst_n && hpm_cs && !cpu_cs) begin
            g_cyc.push_back(cyc);
            g_addr.push_back(hpm_addr);
        end
        if (smp_valid && smp_ready) begin
            p_cyc.push_back(cyc);
            p_word.push_back({smp_last, smp_data});
        end
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic clear_q();
        g_cyc.delete();
        g_addr.delete();
        p_cyc.delete();
        p_word.delete();
    endtask

    task automatic quiesce();
        cfg_enable = 1'b0;
        smp_ready  = 1'b1;
        tick(30);
        clear_q();
    endtask

    // Returns at the READ idx 0 cycle (sampler driving address 0x04).
    task automatic wait_read_start(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 64 && !ok; i++) begin
            tick(1);
            if (busy && !cpu_cs && hpm_addr == 5'h04) ok = 1'b1;
        end
    endtask

    typedef struct {
        logic        cs;
        logic        we;
        logic [4:0]  addr;
        logic [31:0] wdata;
        logic        e_cs;
        logic        e_we;
        logic [4:0]  e_addr;
        logic [31:0] e_wdata;
        logic [31:0] e_rdata;
    } vec_t;

    vec_t        vecs[5];
    logic [4:0]  rec_addr[4];
    logic [32:0] rec_word[4];
    int          starts[$];
    int          n;
    int          t0;
    bit          ok;

    initial begin
        vecs[0] = '{1'b0, 1'b0, 5'h00, 32'h0000_0000, 1'b0, 1'b0, 5'h04, 32'h0, 32'h0};
        vecs[1] = '{1'b1, 1'b0, 5'h00, 32'hDEAD_BEEF, 1'b1, 1'b0, 5'h00, 32'hDEAD_BEEF, 32'hB4A0_1234};
        vecs[2] = '{1'b1, 1'b1, 5'h1F, 32'h0123_4567, 1'b1, 1'b1, 5'h1F, 32'h0123_4567, 32'hB4BF_1234};
        vecs[3] = '{1'b0, 1'b1, 5'h0C, 32'hFFFF_FFFF, 1'b0, 1'b0, 5'h04, 32'h0, 32'h0};
        vecs[4] = '{1'b1, 1'b1, 5'h10, 32'h8000_0001, 1'b1, 1'b1, 5'h10, 32'h8000_0001, 32'hB4B0_1234};
        rec_addr = '{5'h04, 5'h08, 5'h0C, 5'h10};
        rec_word = '{{1'b0, 32'hB4A4_1234}, {1'b0, 32'hB4A8_1234},
                     {1'b0, 32'hB4AC_1234}, {1'b1, 32'hB4B0_1234}};

        tick(3);
        check("rst_smp_valid", smp_valid, 0);
        check("rst_smp_last", smp_last, 0);
        check("rst_smp_data", smp_data, 0);
        check("rst_drop_cnt", drop_cnt, 0);
        check("rst_busy", busy, 0);
        check("rst_hpm_cs", hpm_cs, 0);
        rst_n = 1'b1;
        tick(2);

        // Port mux table, sampler idle
        for (int i = 0; i < 5; i++) begin
            cpu_cs = vecs[i].cs; cpu_we = vecs[i].we;
            cpu_addr = vecs[i].addr; cpu_wdata = vecs[i].wdata;
            #1;
            check($sformatf("mux%0d_hpm_cs", i), hpm_cs, vecs[i].e_cs);
            check($sformatf("mux%0d_hpm_we", i), hpm_we, vecs[i].e_we);
            check($sformatf("mux%0d_hpm_wdata", i), hpm_wdata, vecs[i].e_wdata);
            check($sformatf("mux%0d_cpu_rdata", i), cpu_rdata, vecs[i].e_rdata);
            if (vecs[i].cs) check($sformatf("mux%0d_hpm_addr", i), hpm_addr, vecs[i].e_addr);
            tick(1);
        end
        cpu_cs = 1'b0; cpu_we = 1'b0; cpu_addr = 5'h00; cpu_wdata = 32'h0;
        tick(1);

        // Interval 10, free-running consumer
        clear_q();
        cfg_interval = 32'd10; smp_ready = 1'b1; cfg_enable = 1'b1;
        tick(48);
        check("a_grants", g_addr.size() >= 12, 1);
        for (int i = 0; i < 4; i++) check($sformatf("a_addr%0d", i), g_addr[i], rec_addr[i]);
        for (int i = 0; i < 4; i++) check($sformatf("a_word%0d", i), p_word[i], rec_word[i]);
        check("a_first_word_latency", p_cyc[0] - g_cyc[0], 1);
        starts.delete();
        foreach (g_addr[i]) if (g_addr[i] == 5'h04) starts.push_back(g_cyc[i]);
        check("a_period1", starts[1] - starts[0], 10);
        check("a_period2", starts[2] - starts[1], 10);
        check("a_drop", drop_cnt, 0);

        // Interval 1 clamps to 4: back-to-back records
        quiesce();
        cfg_interval = 32'd1; cfg_enable = 1'b1;
        tick(30);
        for (int i = 0; i < 8; i++) check($sformatf("b_addr%0d", i), g_addr[i], rec_addr[i % 4]);
        check("b_last3", p_word[3][32], 1);
        check("b_last7", p_word[7][32], 1);
        starts.delete();
        foreach (g_addr[i]) if (g_addr[i] == 5'h04) starts.push_back(g_cyc[i]);
        check("b_period1", starts[1] - starts[0], 4);
        check("b_period2", starts[2] - starts[1], 4);

        // CPU steals the port for 3 cycles at idx 1
        quiesce();
        cfg_interval = 32'd10; cfg_enable = 1'b1;
        wait_read_start(ok);
        check("c_read_start_timeout", ok, 1);
        tick(1);
        cpu_cs = 1'b1; cpu_we = 1'b0; cpu_addr = 5'h00;
        for (int k = 0; k < 3; k++) begin
            #1;
            check($sformatf("c_cpu_rdata%0d", k), cpu_rdata, 32'hB4A0_1234);
            check($sformatf("c_hpm_addr%0d", k), hpm_addr, 5'h00);
            tick(1);
        end
        cpu_cs = 1'b0;
        #1;
        check("c_resume_addr", hpm_addr, 5'h08);
        tick(6);
        check("c_grants", g_addr.size(), 4);
        check("c_words", p_word.size(), 4);
        for (int i = 0; i < 4; i++) check($sformatf("c_word%0d", i), p_word[i], rec_word[i]);
        check("c_stall_gap", g_cyc[1] - g_cyc[0], 4);

        // Stalled consumer: fill 16 words, then drops
        quiesce();
        smp_ready = 1'b0; cfg_interval = 32'd8; cfg_enable = 1'b1;
        ok = 1'b0;
        for (int i = 0; i < 100 && !ok; i++) begin
            tick(1);
            if (g_addr.size() == 16) ok = 1'b1;
        end
        check("d_fill_timeout", ok, 1);
        check("d_valid_full", smp_valid, 1);
        check("d_drop0", drop_cnt, 0);
        ok = 1'b0;
        for (int i = 0; i < 20 && !ok; i++) begin
            tick(1);
            if (drop_cnt == 1) ok = 1'b1;
        end
        check("d_drop1", drop_cnt, 1);
        for (int d = 2; d <= 3; d++) begin
            n = 0;
            for (int i = 0; i < 20 && drop_cnt != DROP_W'(d); i++) begin
                tick(1);
                n++;
            end
            check($sformatf("d_drop%0d", d), drop_cnt, d);
            check($sformatf("d_drop_gap%0d", d), n, 8);
        end
        check("d_no_push", g_addr.size(), 16);
        check("d_no_pop", p_word.size(), 0);

        // Enable dropped at idx 1 still completes the record
        quiesce();
        cfg_interval = 32'd10; cfg_enable = 1'b1;
        wait_read_start(ok);
        check("e_read_start_timeout", ok, 1);
        tick(1);
        cfg_enable = 1'b0;
        tick(40);
        check("e_grants", g_addr.size(), 4);
        check("e_addr3", g_addr[3], 5'h10);
        check("e_words", p_word.size(), 4);
        check("e_last", p_word[3][32], 1);
        check("e_busy", busy, 0);
        check("e_drop_kept", drop_cnt, 3);

        // Reset mid-READ, then restart with interval 2 (clamped to 4)
        clear_q();
        smp_ready = 1'b0; cfg_interval = 32'd2; cfg_enable = 1'b1;
        wait_read_start(ok);
        check("f_read_start_timeout", ok, 1);
        tick(1);
        check("f_valid_before", smp_valid, 1);
        rst_n = 1'b0;
        #1;
        check("f_rst_valid", smp_valid, 0);
        check("f_rst_drop", drop_cnt, 0);
        check("f_rst_hpm_cs", hpm_cs, 0);
        check("f_rst_busy", busy, 0);
        tick(2);
        rst_n = 1'b1;
        tick(1);
        n = 0;
        for (int i = 0; i < 20 && !busy; i++) begin
            tick(1);
            n++;
        end
        check("f_restart_delay", n, 4);
        check("f_restart_addr", hpm_addr, 5'h04);
        t0 = 0;

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
